// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word, RAM handshake state, arbiter FSM state and grant owner.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE,
        IFETCH,
        DREAD,
        DWRITE,
        DONE
    } arb_state_t;

    typedef enum logic {
        INSTR,
        DATA
    } grant_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of request-unit, fetch-port and RAM signals seen by the memory arbiter.
interface memory_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      ihit;
    word_t     iload;
    logic      dhit;
    word_t     dload;
    logic      merr;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    // Arbiter side: serves the CPU requesters and drives the RAM.
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, iload, dhit, dload, merr, ramREN, ramWEN, ramaddr, ramstore
    );

    // Environment side: the requesters together with the RAM.
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, iload, dhit, dload, merr, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates instruction fetches and data accesses onto one single-ported RAM,
// returning one-cycle hit/error pulses with registered load data.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic             CLK,
    input  logic             nRST,
    memory_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    arb_state_t       state;
    arb_state_t       nextState;
    grant_t           lastGrant;
    logic [CNT_W-1:0] counter;
    logic             accessDone;
    logic             abort;
    logic             wantData;

    assign wantData = bus.dREN | bus.dWEN;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        nextState  = state;
        accessDone = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                // Fetch wins when alone, or when data had the previous grant.
                if (bus.iREN && (!wantData || lastGrant == DATA)) nextState = IFETCH;
                else if (bus.dWEN)                                 nextState = DWRITE;
                else if (bus.dREN)                                 nextState = DREAD;
            end
            IFETCH, DREAD, DWRITE: begin
                if (bus.ramstate == ACCESS) begin
                    accessDone = 1'b1;
                    nextState  = DONE;
                end else if (bus.ramstate == ERROR || counter == LAST_CNT) begin
                    abort     = 1'b1;
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!nRST) begin
            state        <= IDLE;
            lastGrant    <= INSTR;
            counter      <= '0;
            bus.ihit     <= 1'b0;
            bus.dhit     <= 1'b0;
            bus.merr     <= 1'b0;
            bus.ramREN   <= 1'b0;
            bus.ramWEN   <= 1'b0;
            bus.iload    <= '0;
            bus.dload    <= '0;
            bus.ramaddr  <= '0;
            bus.ramstore <= '0;
        end else begin
            state    <= nextState;
            bus.ihit <= 1'b0;
            bus.dhit <= 1'b0;
            bus.merr <= 1'b0;
            case (state)
                IDLE: begin
                    if (nextState != IDLE) begin
                        counter     <= '0;
                        lastGrant   <= (nextState == IFETCH) ? INSTR : DATA;
                        bus.ramaddr <= (nextState == IFETCH) ? bus.iaddr : bus.daddr;
                        bus.ramREN  <= (nextState != DWRITE);
                        bus.ramWEN  <= (nextState == DWRITE);
                        if (nextState == DWRITE) bus.ramstore <= bus.dstore;
                    end
                end
                IFETCH, DREAD, DWRITE: begin
                    if (counter != LAST_CNT) counter <= counter + 1'b1;
                    if (nextState == DONE) begin
                        bus.ramREN <= 1'b0;
                        bus.ramWEN <= 1'b0;
                        bus.ihit   <= accessDone && (state == IFETCH);
                        bus.dhit   <= accessDone && (state != IFETCH);
                        bus.merr   <= abort;
                        if (accessDone && state == IFETCH) bus.iload <= bus.ramload;
                        if (accessDone && state == DREAD)  bus.dload <= bus.ramload;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
